radix2_divider: RTL and testbench

//  Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.

---
 rtl/radix2_divider_if.sv | 29 ++
 rtl/radix2_divider.sv | 144 ++++++++++++++
 tb/tb_radix2_divider.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/radix2_divider_if.sv
// rtl/radix2_divider_if.sv - FU state type and start/valid interface of the radix-2 divider
package radix2_divider_pkg;
  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
endpackage

interface radix2_divider_if #(parameter int DATA_WIDTH = 32);
  import radix2_divider_pkg::*;

  logic                  start_i;
  logic                  kill_i;
  logic [1:0]            op_i;
  logic [DATA_WIDTH-1:0] op_A_i;
  logic [DATA_WIDTH-1:0] op_B_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  valid_o;
  fu_state_e             fu_state_o;

  // Issue logic side: drives requests, observes result and occupancy
  modport master (
    output start_i, kill_i, op_i, op_A_i, op_B_i,
    input  result_o, valid_o, fu_state_o
  );

  // Divider side
  modport slave (
    input  start_i, kill_i, op_i, op_A_i, op_B_i,
    output result_o, valid_o, fu_state_o
  );
endinterface

// File: rtl/radix2_divider.sv
// rtl/radix2_divider.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module radix2_divider
  import radix2_divider_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic             clk_i,
  input logic             rst_n_i,
  radix2_divider_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] div_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  q_neg_q;
  logic                  r_neg_q;
  logic                  sel_rem_q;
  logic                  valid_q;
  fu_state_e             fu_state_q;

  logic                  is_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic                  div_by_zero;
  logic                  overflow;
  logic                  accept;
  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;
  logic [DATA_WIDTH:0]   partial;
  logic [DATA_WIDTH:0]   trial;

  // Operand conditioning for a new request and the trial subtraction of one divide step
  always_comb begin
    is_signed   = ~bus.op_i[0];
    a_neg       = is_signed & bus.op_A_i[DATA_WIDTH-1];
    b_neg       = is_signed & bus.op_B_i[DATA_WIDTH-1];
    // |MIN| wraps to MIN, which is the correct magnitude when read as unsigned
    abs_a       = a_neg ? -bus.op_A_i : bus.op_A_i;
    abs_b       = b_neg ? -bus.op_B_i : bus.op_B_i;
    div_by_zero = (bus.op_B_i == '0);
    overflow    = is_signed && (bus.op_A_i == MIN_VAL) && (bus.op_B_i == '1);
    // The cycle showing valid_o still belongs to the finishing operation
    accept      = bus.start_i & ~bus.kill_i & ~valid_q;
    partial     = {rem_q, quo_q[DATA_WIDTH-1]};
    trial       = partial - {1'b0, div_q};
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      sel_rem_q  <= 1'b0;
      valid_q    <= 1'b0;
      fu_state_q <= FREE;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          fu_state_q <= FREE;
          if (accept) begin
            sel_rem_q  <= bus.op_i[1];
            fu_state_q <= BUSY;
            if (div_by_zero) begin
              quo_q   <= '1;
              rem_q   <= bus.op_A_i;
              state_q <= DONE;
            end else if (overflow) begin
              quo_q   <= MIN_VAL;
              rem_q   <= '0;
              state_q <= DONE;
            end else begin
              quo_q   <= abs_a;
              rem_q   <= '0;
              div_q   <= abs_b;
              cnt_q   <= CNT_W'(DATA_WIDTH - 1);
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              state_q <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (bus.kill_i) begin
            state_q    <= IDLE;
            fu_state_q <= FREE;
          end else begin
            // Restore by keeping the partial remainder when the trial goes negative
            rem_q <= trial[DATA_WIDTH] ? partial[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
            quo_q <= {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
            if (cnt_q == '0) begin
              state_q <= FIXUP;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        FIXUP: begin
          if (bus.kill_i) begin
            state_q    <= IDLE;
            fu_state_q <= FREE;
          end else begin
            quo_q   <= q_neg_q ? -quo_q : quo_q;
            rem_q   <= r_neg_q ? -rem_q : rem_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (bus.kill_i) begin
            fu_state_q <= FREE;
          end else begin
            // Stay BUSY through the valid cycle; FREE is restored on the next edge
            result_q <= sel_rem_q ? rem_q : quo_q;
            valid_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          fu_state_q <= FREE;
        end
      endcase
    end
  end

  assign bus.result_o   = result_q;
  assign bus.valid_o    = valid_q;
  assign bus.fu_state_o = fu_state_q;

endmodule

// File: tb/tb_radix2_divider.sv
// tb/tb_radix2_divider.sv - self-checking bench for radix2_divider
module tb_radix2_divider;
  import radix2_divider_pkg::*;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;
  localparam int LAT_NORMAL = W + 2;
  localparam int LAT_SPECIAL = 1;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  radix2_divider_if #(.DATA_WIDTH(W)) bus ();

  radix2_divider #(.DATA_WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics from plain 64-bit arithmetic
  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? W'(sa % sb) : W'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (b == '0) return LAT_SPECIAL;
    if (!op[0] && a == MIN_VAL && b == '1) return LAT_SPECIAL;
    return LAT_NORMAL;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return MIN_VAL;
      1: return '1;
      2: return '0;
      3: return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  task automatic wait_free();
    for (int g = 0; g < 100 && bus.fu_state_o != FREE; g++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Issue one request and return its result and the number of edges to valid_o (0 = timeout)
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat);
    wait_free();
    bus.op_i    = op;
    bus.op_A_i  = a;
    bus.op_B_i  = b;
    bus.start_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    res = '0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk_i);
      #1;
      if (bus.valid_o) begin
        lat = k;
        res = bus.result_o;
        break;
      end
    end
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk_i);
      #1;
      if (bus.valid_o) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] res;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    int           lat, cnt, first_v, second_v;

    vecs[0]  = '{OP_DIVU, 32'd100,       32'd7,         32'd14,        LAT_NORMAL,  "divu_100_7"};
    vecs[1]  = '{OP_REMU, 32'd100,       32'd7,         32'd2,         LAT_NORMAL,  "remu_100_7"};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORMAL,  "div_m7_2"};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_NORMAL,  "rem_m7_2"};
    vecs[4]  = '{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_NORMAL,  "rem_7_m2"};
    vecs[5]  = '{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPECIAL, "divu_5_0"};
    vecs[6]  = '{OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, LAT_SPECIAL, "rem_m5_0"};
    vecs[7]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL, "div_min_m1"};
    vecs[8]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPECIAL, "rem_min_m1"};
    vecs[9]  = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_NORMAL,  "divu_min_max"};
    vecs[10] = '{OP_DIV,  32'h8000_0000, 32'd1,         32'h8000_0000, LAT_NORMAL,  "div_min_1"};
    vecs[11] = '{OP_REMU, 32'hFFFF_FFFF, 32'd16,        32'd15,        LAT_NORMAL,  "remu_max_16"};
    vecs[12] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORMAL,  "div_7_m2"};

    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    bus.op_i    = OP_DIV;
    bus.op_A_i  = '0;
    bus.op_B_i  = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_fu_state", 32'(bus.fu_state_o), 32'(FREE));
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].res);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // start_i held high: one acceptance per free slot, the valid cycle is not a free slot
    wait_free();
    bus.op_i    = OP_DIVU;
    bus.op_A_i  = 32'd100;
    bus.op_B_i  = 32'd7;
    bus.start_i = 1'b1;
    cnt = 0;
    first_v = -1;
    second_v = -1;
    for (int k = 0; k < 72; k++) begin
      @(posedge clk_i);
      #1;
      if (bus.valid_o) begin
        cnt++;
        if (first_v < 0) first_v = k;
        else if (second_v < 0) second_v = k;
      end
    end
    bus.start_i = 1'b0;
    check("held_start_valid_count", 32'(cnt), 32'd2);
    check("held_start_first_edge", 32'(first_v), 32'(LAT_NORMAL));
    check("held_start_second_edge", 32'(second_v), 32'(2 * LAT_NORMAL + 2));

    // kill_i mid-divide: no valid_o, result_o keeps the previous value
    run_op(OP_REMU, 32'd100, 32'd7, res, lat);
    check("pre_kill_result", res, 32'd2);
    wait_free();
    bus.op_i    = OP_DIV;
    bus.op_A_i  = 32'd1000;
    bus.op_B_i  = 32'd3;
    bus.start_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("busy_before_kill", 32'(bus.fu_state_o), 32'(BUSY));
    bus.kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.kill_i = 1'b0;
    check("kill_fu_state", 32'(bus.fu_state_o), 32'(FREE));
    count_valids(40, cnt);
    check("kill_no_valid", 32'(cnt), 32'd0);
    check("kill_result_kept", bus.result_o, 32'd2);

    // kill_i together with start_i in IDLE drops the request
    bus.op_i    = OP_DIVU;
    bus.op_A_i  = 32'd9;
    bus.op_B_i  = 32'd0;
    bus.start_i = 1'b1;
    bus.kill_i  = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    check("kill_start_fu_state", 32'(bus.fu_state_o), 32'(FREE));
    count_valids(40, cnt);
    check("kill_start_no_valid", 32'(cnt), 32'd0);

    // Asynchronous reset in the middle of a division
    bus.op_i    = OP_DIV;
    bus.op_A_i  = 32'hFFFF_FF9C;
    bus.op_B_i  = 32'd7;
    bus.start_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("midreset_fu_state", 32'(bus.fu_state_o), 32'(FREE));
    check("midreset_valid", 32'(bus.valid_o), 32'd0);
    check("midreset_result", bus.result_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    count_valids(40, cnt);
    check("midreset_no_valid", 32'(cnt), 32'd0);

    // Randomized sweep against the arithmetic reference
    for (int n = 0; n < 1500; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, res, lat);
      check($sformatf("rand%0d_op%0d_%h_%h_result", n, op, a, b), res, ref_result(op, a, b));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_latency(op, a, b)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
